// File: rtl/logicnet_input_packer_if.sv
// Valid/ready stream carrying either single quantized features (input side)
// or whole packed vectors (output side) of the LUT-network front end.
interface logicnet_input_packer_if #(
  parameter int W = 2
) ();
  logic         valid;
  logic         ready;
  logic         last;
  logic [W-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/logicnet_input_packer.sv
// Serial-to-parallel packer: collects NUM_FEAT features per sample into one
// bit-packed vector, double buffered so assembly continues while a vector is held.
module logicnet_input_packer #(
  parameter int          FEAT_BW     = 2,
  parameter int          NUM_FEAT    = 8,
  // Reset value of the handoff counter; nonzero only to reach the wrap quickly.
  parameter logic [15:0] VEC_CNT_RST = 16'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  logicnet_input_packer_if.slave  s_if,
  logicnet_input_packer_if.master m_if,
  output logic                    o_err_len,
  output logic [15:0]             o_vec_cnt
);

  localparam int                CNT_W    = $clog2(NUM_FEAT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_FEAT - 1);

  logic [CNT_W-1:0]                 r_cnt;
  logic [NUM_FEAT-1:0][FEAT_BW-1:0] r_asm;
  logic                             r_asm_full;
  logic [NUM_FEAT*FEAT_BW-1:0]      r_m_data;
  logic                             r_m_valid;
  logic                             r_err_len;
  logic [15:0]                      r_vec_cnt;

  logic                             w_beat;
  logic                             w_at_end;
  logic                             w_final;
  logic                             w_early;
  logic                             w_handoff;
  logic                             w_slot_free;
  logic [NUM_FEAT-1:0][FEAT_BW-1:0] w_vec;

  // Ready depends only on registered state (and reset), never on m_if.ready.
  assign s_if.ready  = rst_n && !r_asm_full;
  assign m_if.valid  = r_m_valid;
  assign m_if.data   = r_m_data;
  assign m_if.last   = 1'b1;
  assign o_err_len   = r_err_len;
  assign o_vec_cnt   = r_vec_cnt;

  assign w_beat      = s_if.valid && s_if.ready;
  assign w_at_end    = (r_cnt == LAST_IDX);
  assign w_final     = w_beat && w_at_end;
  assign w_early     = w_beat && s_if.last && !w_at_end;
  assign w_handoff   = r_m_valid && m_if.ready;
  assign w_slot_free = !r_m_valid || m_if.ready;

  // Completed vector: assembled slots plus the feature arriving on the final beat.
  // NOTE: every variable assigned in always_comb gets a full default first so no latch is inferred.
  always_comb begin
    w_vec               = r_asm;
    w_vec[NUM_FEAT-1]   = s_if.data;
  end

  // NOTE: the assembly slots carry no reset; cnt alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (w_beat) r_asm[r_cnt] <= s_if.data;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_asm_full <= 1'b0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_err_len  <= 1'b0;
      r_vec_cnt  <= VEC_CNT_RST;
    end else begin
      r_err_len <= w_early || (w_final && !s_if.last);

      if (w_early || w_final) r_cnt <= '0;
      else if (w_beat)        r_cnt <= r_cnt + 1'b1;

      if (w_handoff) r_vec_cnt <= r_vec_cnt + 16'd1;

      // A completed sample goes straight out if the output slot frees up this
      // edge, otherwise it waits in the assembly buffer.
      if (w_final && w_slot_free) begin
        r_m_data  <= w_vec;
        r_m_valid <= 1'b1;
      end else if (w_final) begin
        r_asm_full <= 1'b1;
      end else if (w_handoff && r_asm_full) begin
        r_m_data   <= r_asm;
        r_asm_full <= 1'b0;
      end else if (w_handoff) begin
        r_m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logicnet_input_packer.sv
// Self-checking bench for logicnet_input_packer: directed scenarios plus a
// randomized run checked against a queue-based model of samples and vectors.
module tb_logicnet_input_packer;

  localparam int FB = 2;
  localparam int NF = 8;
  localparam int VW = FB * NF;

  logic clk;
  logic rst_n;
  logic err_len, w_err_len;
  logic [15:0] vec_cnt, w_vec_cnt;

  logicnet_input_packer_if #(.W(FB)) s_if ();
  logicnet_input_packer_if #(.W(VW)) m_if ();
  logicnet_input_packer_if #(.W(FB)) ws_if ();
  logicnet_input_packer_if #(.W(VW)) wm_if ();

  logicnet_input_packer #(.FEAT_BW(FB), .NUM_FEAT(NF)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_if(s_if.slave), .m_if(m_if.master),
    .o_err_len(err_len), .o_vec_cnt(vec_cnt)
  );

  logicnet_input_packer #(.FEAT_BW(FB), .NUM_FEAT(NF), .VEC_CNT_RST(16'hFFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .s_if(ws_if.slave), .m_if(wm_if.master),
    .o_err_len(w_err_len), .o_vec_cnt(w_vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: features of the sample in progress, and vectors owed downstream.
  logic [FB-1:0] feat_q[$];
  logic [VW-1:0] exp_q[$];
  logic [15:0]   exp_vcnt;
  logic          exp_err;

  logic          got_beat, got_hand;
  logic [VW-1:0] got_data, hand_exp;

  // One clock cycle: drive at the falling edge, sample the handshake, advance
  // the model exactly as the rules say the edge behaves, end on the next falling edge.
  task automatic cyc(input logic v, input logic [FB-1:0] d, input logic l, input logic mr);
    logic [VW-1:0] vec;
    s_if.valid = v; s_if.data = d; s_if.last = l; m_if.ready = mr;
    #1;
    got_beat = v && s_if.ready;
    got_hand = m_if.valid && mr;
    got_data = m_if.data;
    hand_exp = 'x;
    if (got_hand) begin
      if (exp_q.size() > 0) hand_exp = exp_q.pop_front();
      exp_vcnt = exp_vcnt + 16'd1;
    end
    exp_err = 1'b0;
    if (got_beat) begin
      feat_q.push_back(d);
      if (l && feat_q.size() < NF) begin
        exp_err = 1'b1;
        feat_q.delete();
      end else if (feat_q.size() == NF) begin
        exp_err = !l;
        vec = '0;
        for (int i = 0; i < NF; i++) vec[i*FB +: FB] = feat_q[i];
        exp_q.push_back(vec);
        feat_q.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_enter();
    rst_n = 1'b0;
    s_if.valid = 1'b0; s_if.last = 1'b0; s_if.data = '0; m_if.ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_release();
    rst_n = 1'b1;
    feat_q.delete();
    exp_q.delete();
    exp_vcnt = 16'd0;
    #1;
  endtask

  task automatic test_reset();
    reset_enter();
    reset_enter();
    vectors++; if (s_if.ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready_low got=%b want=0", s_if.ready); end
    vectors++; if (m_if.valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid got=%b want=0", m_if.valid); end
    vectors++; if (m_if.data !== '0) begin miscompares++; $display("FAIL reset_m_data got=%h want=0", m_if.data); end
    vectors++; if (err_len !== 1'b0) begin miscompares++; $display("FAIL reset_err_len got=%b want=0", err_len); end
    vectors++; if (vec_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_vec_cnt got=%h want=0", vec_cnt); end
    reset_release();
    vectors++; if (s_if.ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready_release got=%b want=1", s_if.ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [FB-1:0] vals [NF] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < NF; i++) cyc(1'b1, vals[i], i == NF-1, 1'b1);
    vectors++; if (m_if.valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got=%b want=1", m_if.valid); end
    vectors++; if (m_if.data !== 16'h1BE4) begin miscompares++; $display("FAIL basic_data got=%h want=1be4", m_if.data); end
    cyc(1'b0, '0, 1'b0, 1'b1);
    vectors++; if (!got_hand || got_data !== hand_exp) begin miscompares++; $display("FAIL basic_hand hand=%b got=%h want=%h", got_hand, got_data, hand_exp); end
    vectors++; if (m_if.valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_drop got=%b want=0", m_if.valid); end
    vectors++; if (vec_cnt !== 16'd1) begin miscompares++; $display("FAIL basic_vec_cnt got=%0d want=1", vec_cnt); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 2*NF; i++) begin
      cyc(1'b1, (i < NF) ? 2'd1 : 2'd2, (i % NF) == NF-1, 1'b0);
      vectors++; if (got_beat !== 1'b1) begin miscompares++; $display("FAIL bp_accept beat=%0d got=%b want=1", i, got_beat); end
    end
    vectors++; if (m_if.data !== 16'h5555 || m_if.valid !== 1'b1) begin miscompares++; $display("FAIL bp_held got=%h/%b want=5555/1", m_if.data, m_if.valid); end
    vectors++; if (s_if.ready !== 1'b0) begin miscompares++; $display("FAIL bp_s_ready_low got=%b want=0", s_if.ready); end
    cyc(1'b0, '0, 1'b0, 1'b1);
    vectors++; if (!got_hand || got_data !== hand_exp) begin miscompares++; $display("FAIL bp_hand1 got=%h want=%h", got_data, hand_exp); end
    vectors++; if (m_if.data !== 16'hAAAA || m_if.valid !== 1'b1) begin miscompares++; $display("FAIL bp_second got=%h/%b want=aaaa/1", m_if.data, m_if.valid); end
    vectors++; if (s_if.ready !== 1'b1) begin miscompares++; $display("FAIL bp_s_ready_back got=%b want=1", s_if.ready); end
    // Final beat of a new sample coincides with the handoff of the held vector.
    for (int i = 0; i < NF; i++) cyc(1'b1, FB'($urandom_range(3, 0)), i == NF-1, i == NF-1);
    vectors++; if (!got_hand || got_data !== 16'hAAAA) begin miscompares++; $display("FAIL bp_simul_hand got=%h want=aaaa", got_data); end
    vectors++; if (m_if.valid !== 1'b1 || m_if.data !== exp_q[0]) begin miscompares++; $display("FAIL bp_simul_load got=%h/%b want=%h/1", m_if.data, m_if.valid, exp_q[0]); end
    vectors++; if (vec_cnt !== exp_vcnt) begin miscompares++; $display("FAIL bp_simul_cnt got=%0d want=%0d", vec_cnt, exp_vcnt); end
    cyc(1'b0, '0, 1'b0, 1'b1);
    vectors++; if (!got_hand || got_data !== hand_exp || m_if.valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got=%h want=%h", got_data, hand_exp); end
  endtask

  task automatic test_back_to_back();
    int last_hand = -1;
    logic [15:0] start_cnt = vec_cnt;
    for (int c = 0; c <= 10*NF; c++) begin
      if (c < 10*NF) cyc(1'b1, FB'($urandom_range(3, 0)), (c % NF) == NF-1, 1'b1);
      else           cyc(1'b0, '0, 1'b0, 1'b1);
      if (c < 10*NF) begin
        vectors++; if (got_beat !== 1'b1) begin miscompares++; $display("FAIL b2b_ready cycle=%0d got=%b want=1", c, got_beat); end
      end
      if (got_hand) begin
        vectors++; if (got_data !== hand_exp) begin miscompares++; $display("FAIL b2b_data cycle=%0d got=%h want=%h", c, got_data, hand_exp); end
        if (last_hand >= 0) begin
          vectors++; if (c - last_hand != NF) begin miscompares++; $display("FAIL b2b_spacing got=%0d want=%0d", c - last_hand, NF); end
        end
        last_hand = c;
      end
    end
    vectors++; if (vec_cnt !== start_cnt + 16'd10) begin miscompares++; $display("FAIL b2b_count got=%0d want=%0d", vec_cnt, start_cnt + 16'd10); end
  endtask

  task automatic test_length_errors();
    for (int i = 0; i < 5; i++) cyc(1'b1, FB'($urandom_range(3, 0)), i == 4, 1'b1);
    vectors++; if (err_len !== 1'b1) begin miscompares++; $display("FAIL len_early_err got=%b want=1", err_len); end
    vectors++; if (m_if.valid !== 1'b0) begin miscompares++; $display("FAIL len_early_novec got=%b want=0", m_if.valid); end
    cyc(1'b0, '0, 1'b0, 1'b1);
    vectors++; if (err_len !== 1'b0 || m_if.valid !== 1'b0) begin miscompares++; $display("FAIL len_early_pulse got=%b/%b want=0/0", err_len, m_if.valid); end
    for (int i = 0; i < NF; i++) cyc(1'b1, FB'($urandom_range(3, 0)), i == NF-1, 1'b1);
    vectors++; if (m_if.valid !== 1'b1 || m_if.data !== exp_q[0] || err_len !== 1'b0) begin miscompares++; $display("FAIL len_recover got=%h/%b/%b want=%h/1/0", m_if.data, m_if.valid, err_len, exp_q[0]); end
    for (int i = 0; i < NF; i++) cyc(1'b1, FB'($urandom_range(3, 0)), 1'b0, 1'b1);
    vectors++; if (err_len !== 1'b1) begin miscompares++; $display("FAIL len_nolast_err got=%b want=1", err_len); end
    vectors++; if (m_if.valid !== 1'b1 || m_if.data !== exp_q[0]) begin miscompares++; $display("FAIL len_nolast_vec got=%h/%b want=%h/1", m_if.data, m_if.valid, exp_q[0]); end
    cyc(1'b0, '0, 1'b0, 1'b1);
    vectors++; if (!got_hand || got_data !== hand_exp || err_len !== 1'b0) begin miscompares++; $display("FAIL len_nolast_hand got=%h/%b want=%h/0", got_data, err_len, hand_exp); end
  endtask

  task automatic test_reset_mid(input bit full);
    int hands = 0;
    if (full) for (int i = 0; i < 2*NF; i++) cyc(1'b1, FB'($urandom_range(3, 0)), (i % NF) == NF-1, 1'b0);
    else      for (int i = 0; i < 3; i++)    cyc(1'b1, FB'($urandom_range(3, 0)), 1'b0, 1'b1);
    reset_enter();
    vectors++; if (m_if.valid !== 1'b0 || m_if.data !== '0 || vec_cnt !== 16'd0 || s_if.ready !== 1'b0)
      begin miscompares++; $display("FAIL rst_mid%0d got v=%b d=%h c=%0d r=%b want 0/0/0/0", full, m_if.valid, m_if.data, vec_cnt, s_if.ready); end
    reset_release();
    for (int c = 0; c < NF + 3; c++) begin
      cyc(c < NF, FB'($urandom_range(3, 0)), c == NF-1, 1'b1);
      if (got_hand) begin
        hands++;
        vectors++; if (got_data !== hand_exp) begin miscompares++; $display("FAIL rst_mid%0d_data got=%h want=%h", full, got_data, hand_exp); end
      end
    end
    vectors++; if (hands != 1 || vec_cnt !== 16'd1) begin miscompares++; $display("FAIL rst_mid%0d_alone hands=%0d cnt=%0d want=1/1", full, hands, vec_cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      logic v, l, mr;
      v  = $urandom_range(3, 0) != 0;
      mr = $urandom_range(4, 0) > 1;
      l  = (feat_q.size() == NF-1) ? ($urandom_range(9, 0) != 0) : ($urandom_range(29, 0) == 0);
      cyc(v, FB'($urandom_range(3, 0)), l, mr);
      if (got_hand) begin
        vectors++; if (got_data !== hand_exp) begin miscompares++; $display("FAIL rnd_data cycle=%0d got=%h want=%h", c, got_data, hand_exp); end
      end
      vectors++; if (err_len !== exp_err) begin miscompares++; $display("FAIL rnd_err cycle=%0d got=%b want=%b", c, err_len, exp_err); end
      vectors++; if (m_if.valid !== (exp_q.size() > 0)) begin miscompares++; $display("FAIL rnd_valid cycle=%0d got=%b want=%b", c, m_if.valid, exp_q.size() > 0); end
      vectors++; if (s_if.ready !== (exp_q.size() < 2)) begin miscompares++; $display("FAIL rnd_ready cycle=%0d got=%b want=%b", c, s_if.ready, exp_q.size() < 2); end
      vectors++; if (vec_cnt !== exp_vcnt) begin miscompares++; $display("FAIL rnd_cnt cycle=%0d got=%0d want=%0d", c, vec_cnt, exp_vcnt); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want;
    want = 16'hFFFE;
    vectors++; if (w_vec_cnt !== want) begin miscompares++; $display("FAIL wrap_start got=%h want=%h", w_vec_cnt, want); end
    wm_if.ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NF; i++) begin
        ws_if.valid = 1'b1; ws_if.data = FB'(i); ws_if.last = (i == NF-1);
        @(posedge clk); @(negedge clk);
      end
      vectors++; if (w_vec_cnt !== want) begin miscompares++; $display("FAIL wrap_step%0d got=%h want=%h", k, w_vec_cnt, want); end
      want = want + 16'd1;
    end
    ws_if.valid = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++; if (w_vec_cnt !== 16'h0001) begin miscompares++; $display("FAIL wrap_end got=%h want=0001", w_vec_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    exp_vcnt = 16'd0;
    ws_if.valid = 1'b0; ws_if.data = '0; ws_if.last = 1'b0; wm_if.ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_length_errors();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
